// File: rtl/udp_filter_arb.sv
// udp_filter_arb
// Frame-granular round-robin arbiter sharing one UDP filter datapath between
// PORTS_NUM ingress streams. One source is granted at a time. The grant is
// held until that source's last beat is accepted. Beats pass through a
// registered valid/ready output stage toward the filter.
//
// Optional feature macro: UDP_ARB_TIMEOUT_EN
//   When defined, a stall watchdog aborts a granted frame whose source has
//   been silent for TIMEOUT_CYCLES cycles. The abort pulses fifo_rst_n_o low.
//
// Ports:
//   clk_i         single clock
//   a_rst_n_i     asynchronous active-low reset
//   en_i          arbitration enable, sampled only when idle
//   s_data_i      packed per-port beats, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_valid_i     per-port beat valid
//   s_last_i      per-port end-of-frame
//   s_ready_o     per-port ready, at most one bit high
//   m_data_o      beat to filter
//   m_valid_o     beat valid
//   m_last_o      end-of-frame
//   m_ready_i     downstream ready
//   grant_o       one-hot current grant, 0 when idle
//   sel_o         index of current or most recent grant
//   busy_o        frame in progress
//   fifo_rst_n_o  downstream FIFO flush, active-low
module udp_filter_arb #(
    parameter int DATA_WIDTH     = 64,
    parameter int PORTS_NUM      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int SEL_WIDTH     = $clog2(PORTS_NUM)
) (
    input  logic                            clk_i,
    input  logic                            a_rst_n_i,
    input  logic                            en_i,
    input  logic [PORTS_NUM*DATA_WIDTH-1:0] s_data_i,
    input  logic [PORTS_NUM-1:0]            s_valid_i,
    input  logic [PORTS_NUM-1:0]            s_last_i,
    output logic [PORTS_NUM-1:0]            s_ready_o,
    output logic [DATA_WIDTH-1:0]           m_data_o,
    output logic                            m_valid_o,
    output logic                            m_last_o,
    input  logic                            m_ready_i,
    output logic [PORTS_NUM-1:0]            grant_o,
    output logic [SEL_WIDTH-1:0]            sel_o,
    output logic                            busy_o,
    output logic                            fifo_rst_n_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam int         CW      = SEL_WIDTH + 1;

    logic [0:0]            state;
    logic                  out_free;
    logic                  src_valid;
    logic                  src_last;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  accept;
    logic                  abort;
    logic                  pick_found;
    logic [SEL_WIDTH-1:0]  pick_idx;
    logic [CW-1:0]         cand;

    assign out_free  = !m_valid_o || m_ready_i;
    assign src_valid = s_valid_i[sel_o];
    assign src_last  = s_last_i[sel_o];
    assign src_data  = s_data_i[sel_o*DATA_WIDTH +: DATA_WIDTH];
    assign accept    = (state == ST_BUSY) && src_valid && out_free;
    assign busy_o    = (state == ST_BUSY);

    // Round-robin search from sel_o+1 upward. The loop runs from the farthest
    // offset down to the nearest so the nearest valid port wins the last write.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = sel_o;
        cand       = '0;
        for (int unsigned i = PORTS_NUM; i >= 1; i--) begin
            cand = {1'b0, sel_o} + CW'(i);
            if (cand >= CW'(PORTS_NUM))
                cand = cand - CW'(PORTS_NUM);
            if (s_valid_i[cand[SEL_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[SEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        s_ready_o = '0;
        if (state == ST_BUSY)
            s_ready_o[sel_o] = out_free;
    end

`ifdef UDP_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] stall_cnt;

    // Only an absent source beat counts as a stall; downstream backpressure
    // holds the counter.
    assign abort = (state == ST_BUSY) && !src_valid &&
                   (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            stall_cnt    <= '0;
            fifo_rst_n_o <= 1'b1;
        end else begin
            fifo_rst_n_o <= !abort;
            if (state != ST_BUSY || accept)
                stall_cnt <= '0;
            else if (!src_valid)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign abort        = 1'b0;
    assign fifo_rst_n_o = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state     <= ST_IDLE;
            grant_o   <= '0;
            sel_o     <= SEL_WIDTH'(PORTS_NUM - 1);
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_i && pick_found) begin
                        state   <= ST_BUSY;
                        sel_o   <= pick_idx;
                        grant_o <= PORTS_NUM'(1) << pick_idx;
                    end
                end
                default: begin
                    if (abort || (accept && src_last)) begin
                        state   <= ST_IDLE;
                        grant_o <= '0;
                    end
                end
            endcase

            // Output stage keeps draining after the grant is released.
            if (abort) begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
            end else if (accept) begin
                m_data_o  <= src_data;
                m_last_o  <= src_last;
                m_valid_o <= 1'b1;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udp_filter_arb.sv
module tb_udp_filter_arb;

    localparam int DW = 64;
    localparam int NP = 4;
    localparam int TO = 8;

    logic            clk_i = 1'b0;
    logic            a_rst_n_i;
    logic            en_i;
    logic [NP*DW-1:0] s_data_i;
    logic [NP-1:0]   s_valid_i;
    logic [NP-1:0]   s_last_i;
    logic [NP-1:0]   s_ready_o;
    logic [DW-1:0]   m_data_o;
    logic            m_valid_o;
    logic            m_last_o;
    logic            m_ready_i;
    logic [NP-1:0]   grant_o;
    logic [1:0]      sel_o;
    logic            busy_o;
    logic            fifo_rst_n_o;

    always #5 clk_i = ~clk_i;

    udp_filter_arb #(
        .DATA_WIDTH     (DW),
        .PORTS_NUM      (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .a_rst_n_i    (a_rst_n_i),
        .en_i         (en_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_last_i     (s_last_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_last_o     (m_last_o),
        .m_ready_i    (m_ready_i),
        .grant_o      (grant_o),
        .sel_o        (sel_o),
        .busy_o       (busy_o),
        .fifo_rst_n_o (fifo_rst_n_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Source model: each port sends src_nframes frames of src_len beats.
    int src_nframes[NP];
    int src_frame[NP];
    int src_beat[NP];
    int src_len[NP];
    int src_base[NP];
    bit src_hold[NP];

    logic [DW-1:0] out_data[$];
    logic          out_last[$];
    int            grant_sel[$];
    int            grant_cyc[$];
    int            onehot_viol;
    int            bp_viol;
    int            fifo_low_cnt;

    function automatic logic [DW-1:0] beat_val(int k, int f, int b);
        return DW'(src_base[k] + f * 16 + b);
    endfunction

    task automatic apply_src();
        for (int k = 0; k < NP; k++) begin
            s_valid_i[k] = (src_frame[k] < src_nframes[k]) && !src_hold[k];
            s_last_i[k]  = (src_beat[k] == src_len[k] - 1);
            s_data_i[k*DW +: DW] = beat_val(k, src_frame[k], src_beat[k]);
        end
    endtask

    task automatic src_clear();
        for (int k = 0; k < NP; k++) begin
            src_nframes[k] = 0;
            src_frame[k]   = 0;
            src_beat[k]    = 0;
            src_len[k]     = 1;
            src_base[k]    = k * 256;
            src_hold[k]    = 1'b0;
        end
    endtask

    // One clock: sample handshakes before the edge, update the model after.
    task automatic cycle();
        logic [NP-1:0] acc;
        logic          pb;
        apply_src();
        #1;
        acc = s_valid_i & s_ready_o;
        if ($countones(s_ready_o) > 1) onehot_viol++;
        if (m_valid_o && !m_ready_i && (s_ready_o != '0)) bp_viol++;
        if (m_valid_o && m_ready_i) begin
            out_data.push_back(m_data_o);
            out_last.push_back(m_last_o);
        end
        pb = busy_o;
        @(posedge clk_i);
        #1;
        cyc++;
        if (!fifo_rst_n_o) fifo_low_cnt++;
        if (!pb && busy_o) begin
            grant_sel.push_back(int'(sel_o));
            grant_cyc.push_back(cyc);
        end
        for (int k = 0; k < NP; k++) begin
            if (acc[k]) begin
                if (src_beat[k] == src_len[k] - 1) begin
                    src_beat[k] = 0;
                    src_frame[k]++;
                end else begin
                    src_beat[k]++;
                end
            end
        end
        apply_src();
    endtask

    task automatic do_reset();
        a_rst_n_i = 1'b0;
        en_i      = 1'b1;
        m_ready_i = 1'b1;
        src_clear();
        apply_src();
        repeat (2) @(posedge clk_i);
        #1;
        a_rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_data.delete();
        out_last.delete();
        grant_sel.delete();
        grant_cyc.delete();
        onehot_viol  = 0;
        bp_viol      = 0;
        fifo_low_cnt = 0;
    endtask

    function automatic bit all_done();
        for (int k = 0; k < NP; k++)
            if (src_frame[k] < src_nframes[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        do_reset();
        tests_run++; if (s_ready_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_s_ready got=%b exp=0000", s_ready_o); end
        tests_run++; if (m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid got=%b exp=0", m_valid_o); end
        tests_run++; if (m_last_o !== 1'b0) begin tests_failed++; $display("FAIL reset_m_last got=%b exp=0", m_last_o); end
        tests_run++; if (m_data_o !== 64'h0) begin tests_failed++; $display("FAIL reset_m_data got=%h exp=0", m_data_o); end
        tests_run++; if (grant_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        tests_run++; if (sel_o !== 2'd3) begin tests_failed++; $display("FAIL reset_sel got=%0d exp=3", sel_o); end
        tests_run++; if (fifo_rst_n_o !== 1'b1) begin tests_failed++; $display("FAIL reset_fifo_rst_n got=%b exp=1", fifo_rst_n_o); end
    endtask

    task automatic test_single_frame();
        do_reset();
        src_nframes[2] = 1;
        src_len[2]     = 3;
        src_base[2]    = 'hA1;
        cycle();
        tests_run++; if (grant_o !== 4'b0100) begin tests_failed++; $display("FAIL single_grant got=%b exp=0100", grant_o); end
        tests_run++; if (sel_o !== 2'd2) begin tests_failed++; $display("FAIL single_sel got=%0d exp=2", sel_o); end
        tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL single_busy got=%b exp=1", busy_o); end
        tests_run++; if (s_ready_o !== 4'b0100) begin tests_failed++; $display("FAIL single_s_ready got=%b exp=0100", s_ready_o); end
        tests_run++; if (m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL single_valid_early got=%b exp=0", m_valid_o); end
        cycle();
        tests_run++; if (m_valid_o !== 1'b1 || m_data_o !== 64'hA1 || m_last_o !== 1'b0) begin tests_failed++; $display("FAIL single_beat1 got v=%b d=%h l=%b exp v=1 d=a1 l=0", m_valid_o, m_data_o, m_last_o); end
        cycle();
        tests_run++; if (m_valid_o !== 1'b1 || m_data_o !== 64'hA2 || m_last_o !== 1'b0) begin tests_failed++; $display("FAIL single_beat2 got v=%b d=%h l=%b exp v=1 d=a2 l=0", m_valid_o, m_data_o, m_last_o); end
        cycle();
        tests_run++; if (m_valid_o !== 1'b1 || m_data_o !== 64'hA3 || m_last_o !== 1'b1) begin tests_failed++; $display("FAIL single_beat3 got v=%b d=%h l=%b exp v=1 d=a3 l=1", m_valid_o, m_data_o, m_last_o); end
        tests_run++; if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin tests_failed++; $display("FAIL single_release got busy=%b grant=%b exp busy=0 grant=0000", busy_o, grant_o); end
        cycle();
        tests_run++; if (m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL single_drain got=%b exp=0", m_valid_o); end
        tests_run++; if (out_data.size() !== 3) begin tests_failed++; $display("FAIL single_count got=%0d exp=3", out_data.size()); end
    endtask

    task automatic test_round_robin();
        int exp_port[5]  = '{0, 1, 2, 3, 0};
        int exp_frame[5] = '{0, 0, 0, 0, 1};
        int idx;
        bit done;
        do_reset();
        for (int k = 0; k < NP; k++) begin
            src_nframes[k] = (k == 0) ? 2 : 1;
            src_len[k]     = 2;
        end
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            cycle();
            done = all_done() && !m_valid_o;
        end
        tests_run++; if (!done) begin tests_failed++; $display("FAIL rr_timeout got=not_done exp=done"); end
        tests_run++; if (grant_sel.size() !== 5) begin tests_failed++; $display("FAIL rr_grant_count got=%0d exp=5", grant_sel.size()); end
        for (int g = 0; g < 5 && g < grant_sel.size(); g++) begin
            tests_run++; if (grant_sel[g] !== exp_port[g]) begin tests_failed++; $display("FAIL rr_grant%0d got=%0d exp=%0d", g, grant_sel[g], exp_port[g]); end
        end
        for (int g = 1; g < grant_cyc.size(); g++) begin
            tests_run++; if (grant_cyc[g] - grant_cyc[g-1] !== 3) begin tests_failed++; $display("FAIL rr_gap%0d got=%0d exp=3", g, grant_cyc[g] - grant_cyc[g-1]); end
        end
        tests_run++; if (out_data.size() !== 10) begin tests_failed++; $display("FAIL rr_beat_count got=%0d exp=10", out_data.size()); end
        for (int i = 0; i < 10 && i < out_data.size(); i++) begin
            idx = i / 2;
            tests_run++;
            if (out_data[i] !== beat_val(exp_port[idx], exp_frame[idx], i % 2) || out_last[i] !== ((i % 2) == 1)) begin
                tests_failed++;
                $display("FAIL rr_beat%0d got d=%h l=%b exp d=%h l=%b", i, out_data[i], out_last[i], beat_val(exp_port[idx], exp_frame[idx], i % 2), (i % 2) == 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        bit done;
        do_reset();
        src_nframes[1] = 1;
        src_len[1]     = 4;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            m_ready_i = pat[3 - (n % 4)];
            cycle();
            done = all_done() && !m_valid_o;
        end
        m_ready_i = 1'b1;
        repeat (3) cycle();
        tests_run++; if (!done) begin tests_failed++; $display("FAIL bp_timeout got=not_done exp=done"); end
        tests_run++; if (out_data.size() !== 4) begin tests_failed++; $display("FAIL bp_beat_count got=%0d exp=4", out_data.size()); end
        for (int i = 0; i < 4 && i < out_data.size(); i++) begin
            tests_run++;
            if (out_data[i] !== beat_val(1, 0, i) || out_last[i] !== (i == 3)) begin
                tests_failed++;
                $display("FAIL bp_beat%0d got d=%h l=%b exp d=%h l=%b", i, out_data[i], out_last[i], beat_val(1, 0, i), i == 3);
            end
        end
        tests_run++; if (bp_viol !== 0) begin tests_failed++; $display("FAIL bp_ready_while_full got=%0d exp=0", bp_viol); end
        tests_run++; if (onehot_viol !== 0) begin tests_failed++; $display("FAIL bp_ready_onehot got=%0d exp=0", onehot_viol); end
    endtask

    task automatic test_enable();
        do_reset();
        src_nframes[1] = 1;
        src_len[1]     = 4;
        for (int n = 0; n < 10 && !busy_o; n++) cycle();
        tests_run++; if (grant_o !== 4'b0010) begin tests_failed++; $display("FAIL en_first_grant got=%b exp=0010", grant_o); end
        cycle();
        en_i = 1'b0;
        src_nframes[0] = 1; src_len[0] = 2;
        src_nframes[3] = 1; src_len[3] = 2;
        repeat (10) cycle();
        tests_run++; if (out_data.size() !== 4) begin tests_failed++; $display("FAIL en_frame_complete got=%0d exp=4", out_data.size()); end
        tests_run++; if (grant_sel.size() !== 1 || busy_o !== 1'b0) begin tests_failed++; $display("FAIL en_blocked got grants=%0d busy=%b exp grants=1 busy=0", grant_sel.size(), busy_o); end
        en_i = 1'b1;
        cycle();
        tests_run++; if (grant_o !== 4'b1000 || sel_o !== 2'd3) begin tests_failed++; $display("FAIL en_resume got grant=%b sel=%0d exp grant=1000 sel=3", grant_o, sel_o); end
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        src_nframes[0] = 1;
        src_len[0]     = 4;
        for (int n = 0; n < 10 && !busy_o; n++) cycle();
        cycle();
        src_hold[0]    = 1'b1;
        src_nframes[1] = 1;
        src_len[1]     = 2;
        early = 0;
        for (int i = 1; i <= 7; i++) begin
            cycle();
            if (!fifo_rst_n_o || !busy_o) early++;
        end
        tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL to_early_abort got=%0d exp=0", early); end
        cycle();
`ifdef UDP_ARB_TIMEOUT_EN
        tests_run++; if (fifo_rst_n_o !== 1'b0) begin tests_failed++; $display("FAIL to_flush got=%b exp=0", fifo_rst_n_o); end
        tests_run++; if (busy_o !== 1'b0 || grant_o !== 4'b0000 || m_valid_o !== 1'b0) begin tests_failed++; $display("FAIL to_abort got busy=%b grant=%b valid=%b exp 0 0000 0", busy_o, grant_o, m_valid_o); end
        tests_run++; if (sel_o !== 2'd0) begin tests_failed++; $display("FAIL to_sel_kept got=%0d exp=0", sel_o); end
        cycle();
        tests_run++; if (fifo_rst_n_o !== 1'b1) begin tests_failed++; $display("FAIL to_flush_release got=%b exp=1", fifo_rst_n_o); end
        tests_run++; if (grant_o !== 4'b0010 || sel_o !== 2'd1) begin tests_failed++; $display("FAIL to_next_grant got grant=%b sel=%0d exp grant=0010 sel=1", grant_o, sel_o); end
        repeat (4) cycle();
        tests_run++; if (fifo_low_cnt !== 1) begin tests_failed++; $display("FAIL to_flush_width got=%0d exp=1", fifo_low_cnt); end
`else
        tests_run++; if (busy_o !== 1'b1 || grant_o !== 4'b0001) begin tests_failed++; $display("FAIL to_no_abort got busy=%b grant=%b exp busy=1 grant=0001", busy_o, grant_o); end
        src_hold[0] = 1'b0;
        repeat (10) cycle();
        tests_run++; if (src_frame[0] !== 1) begin tests_failed++; $display("FAIL to_frame_resumes got=%0d exp=1", src_frame[0]); end
        tests_run++; if (fifo_low_cnt !== 0) begin tests_failed++; $display("FAIL to_fifo_const got=%0d exp=0", fifo_low_cnt); end
`endif
    endtask

    task automatic test_reset_midframe();
        do_reset();
        src_nframes[2] = 1;
        src_len[2]     = 4;
        for (int n = 0; n < 10 && !busy_o; n++) cycle();
        cycle();
        cycle();
        #3;
        a_rst_n_i = 1'b0;
        #1;
        tests_run++; if (s_ready_o !== 4'b0000 || m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_data_o !== 64'h0) begin tests_failed++; $display("FAIL mid_rst_out got rdy=%b v=%b l=%b d=%h exp 0000 0 0 0", s_ready_o, m_valid_o, m_last_o, m_data_o); end
        tests_run++; if (grant_o !== 4'b0000 || busy_o !== 1'b0 || sel_o !== 2'd3 || fifo_rst_n_o !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_ctl got grant=%b busy=%b sel=%0d fifo=%b exp 0000 0 3 1", grant_o, busy_o, sel_o, fifo_rst_n_o); end
        src_clear();
        src_nframes[1] = 1; src_len[1] = 2;
        src_nframes[3] = 1; src_len[3] = 2;
        apply_src();
        @(posedge clk_i);
        #1;
        a_rst_n_i = 1'b1;
        for (int n = 0; n < 10 && !busy_o; n++) cycle();
        tests_run++; if (grant_o !== 4'b0010 || sel_o !== 2'd1) begin tests_failed++; $display("FAIL mid_rst_first_grant got grant=%b sel=%0d exp grant=0010 sel=1", grant_o, sel_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=time_limit exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n_i = 1'b0;
        en_i      = 1'b1;
        m_ready_i = 1'b1;
        s_data_i  = '0;
        s_valid_i = '0;
        s_last_i  = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_timeout();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
